// File: rtl/tu12_pkg.sv
// tu12_pkg: shared constants and the rotating-priority pick used by the TU-12 read scheduler.
package tu12_pkg;
  localparam int NCH = 21;
  localparam int IDX_W = 5;
  typedef logic [NCH-1:0] ch_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [IDX_W:0] sum_t;
  typedef struct packed {
    logic found;
    idx_t idx;
  } pick_t;
  // Scanning from the far end down lets the candidate nearest ptr overwrite the others.
  function automatic pick_t rr_pick(input ch_t mask, input idx_t ptr);
    pick_t p;
    sum_t s;
    p = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      s = {1'b0, ptr} + sum_t'(i);
      if (s >= sum_t'(NCH)) s = s - sum_t'(NCH);
      if (mask[s[IDX_W-1:0]]) p = '{found: 1'b1, idx: s[IDX_W-1:0]};
    end
    return p;
  endfunction
endpackage

// File: rtl/tu12_rr_arb.sv
// tu12_rr_arb: combinational 21-way rotating priority encoder.
module tu12_rr_arb
  import tu12_pkg::*;
(
  input  logic [NCH-1:0]   mask,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);
  assign {found, idx} = rr_pick(mask, ptr);
endmodule

// File: rtl/tu12_rd_sched.sv
// tu12_rd_sched: round-robin read scheduler issuing one-hot endi pulses for 21 TU-12 channels.
module tu12_rd_sched
  import tu12_pkg::*;
#(
  parameter int GAP = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rxsof,
  input  logic [NCH-1:0]   req,
  input  logic [NCH-1:0]   chen,
  input  logic             ovf_clr,
  output logic [NCH-1:0]   endi,
  output logic             gnt_vld,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [NCH-1:0]   pend,
  output logic [NCH-1:0]   ovf
);
  logic [IDX_W-1:0] ptr;
  logic [3:0] gap_cnt;
  logic found;
  logic [IDX_W-1:0] idx;
  logic grant;
  logic [NCH-1:0] gmask;
  tu12_rr_arb u_arb (
    .mask (pend & chen),
    .ptr  (ptr),
    .found(found),
    .idx  (idx)
  );
  always_comb grant = found && gap_cnt == 4'd0 && !rxsof;
  always_comb gmask = grant ? ch_t'(1) << idx : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      endi    <= '0;
      gnt_vld <= 1'b0;
      gnt_idx <= '0;
      pend    <= '0;
      ovf     <= '0;
      ptr     <= '0;
      gap_cnt <= '0;
    end else begin
      endi    <= gmask;
      gnt_vld <= grant;
      if (grant) gnt_idx <= idx;
      // A request landing on its own grant cycle is re-pended rather than flagged.
      pend    <= chen & ((pend & ~gmask) | req);
      ovf     <= (ovf & ~{NCH{ovf_clr}}) | (req & chen & pend & ~gmask);
      ptr     <= rxsof ? '0 : grant ? (idx == idx_t'(NCH - 1) ? '0 : idx + 1'b1) : ptr;
      gap_cnt <= rxsof ? '0 : grant ? 4'(GAP) : gap_cnt - {3'b0, |gap_cnt};
    end
  end
endmodule

// File: tb/tb_tu12_rd_sched.sv
// tb_tu12_rd_sched: directed checks of the read scheduler with GAP=0 and GAP=2 instances.
module tb_tu12_rd_sched;
  import tu12_pkg::*;
  logic clk = 1'b0;
  logic rst, rxsof, ovf_clr;
  logic [NCH-1:0] req, chen;
  logic [NCH-1:0] a_endi, a_pend, a_ovf, b_endi, b_pend, b_ovf;
  logic a_vld, b_vld;
  logic [IDX_W-1:0] a_idx, b_idx;
  int checks = 0;
  int errors = 0;
  tu12_rd_sched #(.GAP(0)) dut_a (
    .clk(clk), .rst(rst), .rxsof(rxsof), .req(req), .chen(chen), .ovf_clr(ovf_clr),
    .endi(a_endi), .gnt_vld(a_vld), .gnt_idx(a_idx), .pend(a_pend), .ovf(a_ovf)
  );
  tu12_rd_sched #(.GAP(2)) dut_b (
    .clk(clk), .rst(rst), .rxsof(rxsof), .req(req), .chen(chen), .ovf_clr(ovf_clr),
    .endi(b_endi), .gnt_vld(b_vld), .gnt_idx(b_idx), .pend(b_pend), .ovf(b_ovf)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1; req = '0; rxsof = 1'b0; ovf_clr = 1'b0; chen = '1;
    step();
    step();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1; req = '1; chen = '1; rxsof = 1'b0; ovf_clr = 1'b0;
    repeat (3) step();
    checks++;
    if (a_endi !== '0 || a_pend !== '0 || a_ovf !== '0 || a_idx !== '0 || a_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset: endi=%h pend=%h ovf=%h idx=%0d vld=%b, want all zero", a_endi, a_pend, a_ovf, a_idx, a_vld);
    end
    rst = 1'b0;
    req = '1;
    step();
    req = '0;
    checks++;
    if (a_pend !== 21'h1FFFFF) begin
      errors++;
      $display("FAIL reset_pend_all: pend=%h want 1fffff", a_pend);
    end
    for (int i = 0; i < NCH; i++) begin
      step();
      checks++;
      if (a_endi !== ch_t'(1) << i || a_idx !== idx_t'(i) || a_vld !== 1'b1) begin
        errors++;
        $display("FAIL walk[%0d]: endi=%h idx=%0d vld=%b want endi=%h idx=%0d vld=1", i, a_endi, a_idx, a_vld, ch_t'(1) << i, i);
      end
    end
    step();
    checks++;
    if (a_endi !== '0 || a_vld !== 1'b0 || a_idx !== 5'd20) begin
      errors++;
      $display("FAIL walk_end: endi=%h vld=%b idx=%0d want 0,0,20", a_endi, a_vld, a_idx);
    end
  endtask
  task automatic test_wrap();
    do_reset();
    req = ch_t'(1) << 3;
    step();
    req = '0;
    step();
    checks++;
    if (a_endi !== ch_t'(1) << 3) begin
      errors++;
      $display("FAIL wrap_ch3: endi=%h want %h", a_endi, ch_t'(1) << 3);
    end
    req = (ch_t'(1) << 1) | (ch_t'(1) << 5);
    step();
    req = '0;
    step();
    checks++;
    if (a_endi !== ch_t'(1) << 5 || a_idx !== 5'd5) begin
      errors++;
      $display("FAIL wrap_first: endi=%h idx=%0d want ch5", a_endi, a_idx);
    end
    step();
    checks++;
    if (a_endi !== ch_t'(1) << 1 || a_idx !== 5'd1) begin
      errors++;
      $display("FAIL wrap_second: endi=%h idx=%0d want ch1", a_endi, a_idx);
    end
  endtask
  task automatic test_gap();
    int grants;
    ch_t exp;
    do_reset();
    req = '1;
    step();
    req = '0;
    grants = 0;
    for (int c = 0; c < 66; c++) begin
      step();
      exp = (c % 3 == 0 && c < 63) ? ch_t'(1) << (c / 3) : '0;
      if (b_vld) grants++;
      checks++;
      if (b_endi !== exp || b_vld !== (|exp)) begin
        errors++;
        $display("FAIL gap[%0d]: endi=%h vld=%b want endi=%h", c, b_endi, b_vld, exp);
      end
    end
    checks++;
    if (grants != 21) begin
      errors++;
      $display("FAIL gap_count: grants=%0d want 21", grants);
    end
  endtask
  task automatic test_overflow();
    do_reset();
    req = ch_t'(1);
    step();
    req = '0;
    step();
    req = ch_t'(1) << 7;
    step();
    step();
    req = '0;
    checks++;
    if (b_ovf !== ch_t'(1) << 7) begin
      errors++;
      $display("FAIL ovf_set: ovf=%h want %h", b_ovf, ch_t'(1) << 7);
    end
    step();
    checks++;
    if (b_endi !== ch_t'(1) << 7 || b_ovf !== ch_t'(1) << 7) begin
      errors++;
      $display("FAIL ovf_sticky: endi=%h ovf=%h want endi=ovf=%h", b_endi, b_ovf, ch_t'(1) << 7);
    end
    repeat (3) step();
    checks++;
    if (b_ovf !== ch_t'(1) << 7) begin
      errors++;
      $display("FAIL ovf_hold: ovf=%h want %h", b_ovf, ch_t'(1) << 7);
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    checks++;
    if (b_ovf !== '0) begin
      errors++;
      $display("FAIL ovf_clr: ovf=%h want 0", b_ovf);
    end
    chen = ~(ch_t'(1) << 9);
    req = ch_t'(1) << 9;
    step();
    req = '0;
    checks++;
    if (a_pend !== '0 || a_ovf !== '0) begin
      errors++;
      $display("FAIL mask_pend: pend=%h ovf=%h want 0,0", a_pend, a_ovf);
    end
    step();
    checks++;
    if (a_endi !== '0) begin
      errors++;
      $display("FAIL mask_endi: endi=%h want 0", a_endi);
    end
    chen = '1;
    req = ch_t'(1) << 9;
    step();
    req = '0;
    chen = ~(ch_t'(1) << 9);
    step();
    checks++;
    if (a_endi !== '0 || a_pend !== '0 || a_ovf !== '0) begin
      errors++;
      $display("FAIL chen_drop: endi=%h pend=%h ovf=%h want 0,0,0", a_endi, a_pend, a_ovf);
    end
    chen = '1;
  endtask
  task automatic test_rxsof();
    do_reset();
    req = '1;
    step();
    req = '0;
    repeat (5) step();
    checks++;
    if (a_endi !== ch_t'(1) << 4) begin
      errors++;
      $display("FAIL rxsof_pre: endi=%h want ch4", a_endi);
    end
    rxsof = 1'b1;
    step();
    rxsof = 1'b0;
    checks++;
    if (a_endi !== '0 || a_vld !== 1'b0 || a_pend !== 21'h1FFFE0) begin
      errors++;
      $display("FAIL rxsof_hold: endi=%h vld=%b pend=%h want 0,0,1fffe0", a_endi, a_vld, a_pend);
    end
    step();
    checks++;
    if (a_endi !== ch_t'(1) << 5 || a_idx !== 5'd5) begin
      errors++;
      $display("FAIL rxsof_next: endi=%h idx=%0d want ch5", a_endi, a_idx);
    end
  endtask
  task automatic test_collision();
    do_reset();
    req = ch_t'(1) << 12;
    step();
    step();
    req = '0;
    checks++;
    if (a_endi !== ch_t'(1) << 12 || a_pend !== ch_t'(1) << 12 || a_ovf !== '0) begin
      errors++;
      $display("FAIL collide: endi=%h pend=%h ovf=%h want endi=pend=%h ovf=0", a_endi, a_pend, a_ovf, ch_t'(1) << 12);
    end
    step();
    checks++;
    if (a_endi !== ch_t'(1) << 12 || a_pend !== '0 || a_ovf !== '0) begin
      errors++;
      $display("FAIL collide_regrant: endi=%h pend=%h ovf=%h want endi=%h pend=0 ovf=0", a_endi, a_pend, a_ovf, ch_t'(1) << 12);
    end
  endtask
  initial begin
    test_reset();
    test_wrap();
    test_gap();
    test_overflow();
    test_rxsof();
    test_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
